verificador_contagem: RTL and testbench
=======================================

# verificador_contagem

Sequence checker that consumes the 4-bit count stream produced by the team's free-running up-counter and verifies it sample by sample. It locks onto the first sample, predicts each next value modulo 2^WIDTH, and flags and counts any deviation. It tracks wrap-arounds and re-locks after a configurable run of correct samples. It sits downstream of the counter, in simulation benches and on-chip self-test, as the receiving end of the counter's output.

## Interface
- WIDTH, 4: width of the monitored count.
- ERR_W, 8: width of the error counter; saturates.
- WRAP_W, 8: width of the wrap counter; wraps modulo 2^WRAP_W.
- RESYNC_N, 2: consecutive correct samples needed to return to LOCKED after an error (≥1).

- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- q_in  input  WIDTH  count value under test.
- valid_in  input  1  q_in is sampled on this edge when high.
- locked  output  1  checker is in LOCKED state.
- erro  output  1  mismatch indication; see Configuration.
- err_count  output  ERR_W  number of mismatches, saturating at all-ones.
- wrap_count  output  WRAP_W  number of verified max→0 transitions.
- exp_out  output  WIDTH  value expected on the next valid sample.

## Operation
- States: IDLE, LOCKED, RESYNC. Reset enters IDLE.
- valid_in low: no state, counter or register changes. A non-sticky erro returns to 0.
- IDLE, valid: exp ← q_in+1 (mod 2^WIDTH); go to LOCKED. No compare, no error.
- LOCKED, valid, q_in==exp: exp ← q_in+1. If q_in == 2^WIDTH−1, then wrap_count+1.
- LOCKED, valid, q_in≠exp: erro asserted; err_count+1 (saturating); exp ← q_in+1; good_run ← 0; go to RESYNC.
- RESYNC, valid, match: exp ← q_in+1; good_run+1. When good_run reaches RESYNC_N, go to LOCKED. Wraps are counted in RESYNC as well.
- RESYNC, valid, mismatch: erro asserted; err_count+1; exp ← q_in+1; good_run ← 0; stay in RESYNC.
- A repeated value (stuck counter) is a mismatch. A skip is a mismatch. A reverse step is a mismatch.
- Arithmetic: exp is computed in WIDTH bits, so 2^WIDTH−1 predicts 0. err_count holds at 2^ERR_W−1. wrap_count wraps silently.

## Timing
- All outputs are registered and update on the clk edge that samples valid_in=1. They are visible one cycle after the sample is presented.
- Reset values: locked=0, erro=0, err_count=0, wrap_count=0, exp_out=0, good_run=0, state IDLE.
- rst has priority over valid_in on the same edge. Reset mid-sequence discards lock and all counts. The first post-reset valid sample re-seeds exp.
- locked rises one edge after the first valid sample in IDLE. It falls on the edge of the first mismatch. It rises on the edge of the RESYNC_N-th consecutive match.
- No combinational path from inputs to outputs.

## Configuration
- VERIFICADOR_ERRO_STICKY_EN defined: erro latches to 1 on the first mismatch. It stays 1 until rst, independent of later matches or valid_in.
- Not defined: erro is a single-cycle pulse, high only in the cycle following each mismatching sample edge.
- All other behaviour is identical in both builds.

## Test plan
- Reset then clean run: valid_in=1 continuously, q_in = 0..15,0..15,0..3 (36 samples). Required: locked=1 from cycle 2, err_count=0, wrap_count=2, erro never high, exp_out=4 at end.
- Skip: clean 0..5, then 7,8,9,10 with RESYNC_N=2. Required: erro on the sample 7 edge, err_count=1, locked=0 after 7, locked=1 after sample 9, exp_out=11.
- Stuck value: 3,4,4,4,5,6. Required: err_count=2 (one per repeated 4). The run 4→5→6 re-locks; locked=1 after 6.
- Valid gaps and wrap: 14,(valid_in=0 ×3),15,(gap),0. Required: no errors, wrap_count=1, and outputs hold during gaps.
- Saturation with ERR_W=2: alternate q_in 0,5,0,5… for 8 samples. Required: err_count stops at 3, and locked stays 0.
- Reset mid-operation: assert rst for one cycle after 0..9 with one injected error. Required: all outputs are 0 the next cycle. Then q_in=8,9 gives locked=1, err_count=0, and no erro on sample 8. Run in both macro builds, checking that erro is a pulse vs sticky.

Source files
------------

// File: rtl/verificador_contagem.sv
// Sequence checker for the 4-bit free-running up-counter stream: locks on the first
// sample, predicts q+1 mod 2^WIDTH, counts mismatches and wraps. Optional sticky erro: VERIFICADOR_ERRO_STICKY_EN.
module verificador_contagem #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned RESYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              valid_in,
  output logic              locked,
  output logic              erro,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  exp_out
);

  localparam int unsigned       GR_W      = $clog2(RESYNC_N + 1);
  localparam logic [GR_W-1:0]   GR_LAST   = GR_W'(RESYNC_N - 1);
  localparam logic [WIDTH-1:0]  MAX_VAL   = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  exp_q, exp_nx;
  logic [GR_W-1:0]   good_run, good_run_nx;
  logic [ERR_W-1:0]  err_q, err_nx;
  logic [WRAP_W-1:0] wrap_q, wrap_nx;
  logic              erro_q, erro_nx;
  logic              match, at_max;

  assign match  = (q_in == exp_q);
  assign at_max = (q_in == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      exp_q    <= '0;
      good_run <= '0;
      err_q    <= '0;
      wrap_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      exp_q    <= exp_nx;
      good_run <= good_run_nx;
      err_q    <= err_nx;
      wrap_q   <= wrap_nx;
      erro_q   <= erro_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    exp_nx      = exp_q;
    good_run_nx = good_run;
    err_nx      = err_q;
    wrap_nx     = wrap_q;
`ifdef VERIFICADOR_ERRO_STICKY_EN
    erro_nx     = erro_q;
`else
    erro_nx     = 1'b0;
`endif
    if (valid_in) begin
      // Every valid sample re-seeds the prediction, match or not.
      exp_nx = q_in + WIDTH'(1);
      case (state)
        IDLE: state_nx = LOCKED;
        LOCKED, RESYNC: begin
          if (match) begin
            if (at_max) wrap_nx = wrap_q + WRAP_W'(1);
            if (state == RESYNC) begin
              if (good_run == GR_LAST) begin
                state_nx    = LOCKED;
                good_run_nx = '0;
              end else begin
                good_run_nx = good_run + GR_W'(1);
              end
            end
          end else begin
            erro_nx     = 1'b1;
            good_run_nx = '0;
            state_nx    = RESYNC;
            if (err_q != ERR_MAX) err_nx = err_q + ERR_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign locked     = (state == LOCKED);
  assign erro       = erro_q;
  assign err_count  = err_q;
  assign wrap_count = wrap_q;
  assign exp_out    = exp_q;

endmodule

// File: tb/tb_verificador_contagem.sv
// Directed bench for verificador_contagem; expectations follow the macro build.
module tb_verificador_contagem;

`ifdef VERIFICADOR_ERRO_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q_in;
  logic       valid_in;
  logic       locked, erro;
  logic [7:0] err_count, wrap_count;
  logic [3:0] exp_out;

  logic [3:0] q_sat;
  logic       valid_sat;
  logic       locked_sat, erro_sat;
  logic [1:0] err_sat;
  logic [7:0] wrap_sat;
  logic [3:0] exp_sat;

  int n_checks = 0;
  int n_fail   = 0;
  logic erro_seen;

  always #5 clk = ~clk;

  verificador_contagem #(.WIDTH(4), .ERR_W(8), .WRAP_W(8), .RESYNC_N(2)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .valid_in(valid_in),
    .locked(locked), .erro(erro), .err_count(err_count),
    .wrap_count(wrap_count), .exp_out(exp_out)
  );

  verificador_contagem #(.WIDTH(4), .ERR_W(2), .WRAP_W(8), .RESYNC_N(2)) dut_sat (
    .clk(clk), .rst(rst), .q_in(q_sat), .valid_in(valid_sat),
    .locked(locked_sat), .erro(erro_sat), .err_count(err_sat),
    .wrap_count(wrap_sat), .exp_out(exp_sat)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic do_sample(input logic [3:0] v);
    q_in     = v;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; q_in = '0; valid_sat = 1'b0; q_sat = '0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_locked", 32'(locked), 32'd0);
    check_value("rst_erro",   32'(erro),   32'd0);
    check_value("rst_err",    32'(err_count),  32'd0);
    check_value("rst_wrap",   32'(wrap_count), 32'd0);
    check_value("rst_exp",    32'(exp_out),    32'd0);
    rst = 1'b0;

    // Clean run 0..15,0..15,0..3
    erro_seen = 1'b0;
    for (int i = 0; i < 36; i++) begin
      do_sample(4'(i % 16));
      if (erro) erro_seen = 1'b1;
      if (i == 0)  check_value("clean_lock_first", 32'(locked), 32'd1);
      if (i == 20) check_value("clean_lock_mid",   32'(locked), 32'd1);
    end
    check_value("clean_err",  32'(err_count),  32'd0);
    check_value("clean_wrap", 32'(wrap_count), 32'd2);
    check_value("clean_exp",  32'(exp_out),    32'd4);
    check_value("clean_erro_never", 32'(erro_seen), 32'd0);

    // Skip 5 -> 7
    do_reset();
    for (int i = 0; i < 6; i++) do_sample(4'(i));
    do_sample(4'd7);
    check_value("skip_erro",   32'(erro),      32'd1);
    check_value("skip_err",    32'(err_count), 32'd1);
    check_value("skip_unlock", 32'(locked),    32'd0);
    do_sample(4'd8);
    check_value("skip_still_unlocked", 32'(locked), 32'd0);
    check_value("skip_erro_after",     32'(erro),   32'(STICKY));
    do_sample(4'd9);
    check_value("skip_relock", 32'(locked), 32'd1);
    do_sample(4'd10);
    check_value("skip_exp",     32'(exp_out),   32'd11);
    check_value("skip_err_end", 32'(err_count), 32'd1);

    // Stuck value
    do_reset();
    do_sample(4'd3); do_sample(4'd4); do_sample(4'd4); do_sample(4'd4);
    check_value("stuck_err_mid", 32'(err_count), 32'd2);
    do_sample(4'd5);
    check_value("stuck_not_yet", 32'(locked), 32'd0);
    do_sample(4'd6);
    check_value("stuck_relock", 32'(locked),    32'd1);
    check_value("stuck_err",    32'(err_count), 32'd2);

    // Valid gaps across the wrap
    do_reset();
    do_sample(4'd14);
    gap(1);
    check_value("gap1_exp",    32'(exp_out),    32'd15);
    check_value("gap1_locked", 32'(locked),     32'd1);
    gap(2);
    check_value("gap3_exp",    32'(exp_out),    32'd15);
    check_value("gap3_wrap",   32'(wrap_count), 32'd0);
    do_sample(4'd15);
    check_value("gap_wrap1",   32'(wrap_count), 32'd1);
    check_value("gap_exp0",    32'(exp_out),    32'd0);
    gap(1);
    check_value("gap4_wrap",   32'(wrap_count), 32'd1);
    check_value("gap4_exp",    32'(exp_out),    32'd0);
    do_sample(4'd0);
    check_value("gap_err",     32'(err_count),  32'd0);
    check_value("gap_wrap",    32'(wrap_count), 32'd1);
    check_value("gap_exp1",    32'(exp_out),    32'd1);
    check_value("gap_erro",    32'(erro),       32'd0);

    // Reset mid-operation, with rst and valid_in both high on the same edge
    do_reset();
    for (int i = 0; i < 5; i++) do_sample(4'(i));
    do_sample(4'd6);
    check_value("mid_erro", 32'(erro),      32'd1);
    check_value("mid_err",  32'(err_count), 32'd1);
    do_sample(4'd7); do_sample(4'd8); do_sample(4'd9);
    check_value("mid_relock",     32'(locked), 32'd1);
    check_value("mid_erro_later", 32'(erro),   32'(STICKY));
    rst = 1'b1; q_in = 4'd5; valid_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; valid_in = 1'b0;
    check_value("mrst_locked", 32'(locked),     32'd0);
    check_value("mrst_erro",   32'(erro),       32'd0);
    check_value("mrst_err",    32'(err_count),  32'd0);
    check_value("mrst_wrap",   32'(wrap_count), 32'd0);
    check_value("mrst_exp",    32'(exp_out),    32'd0);
    do_sample(4'd8);
    check_value("reseed_locked", 32'(locked),    32'd1);
    check_value("reseed_erro",   32'(erro),      32'd0);
    check_value("reseed_exp",    32'(exp_out),   32'd9);
    do_sample(4'd9);
    check_value("reseed2_locked", 32'(locked),    32'd1);
    check_value("reseed2_err",    32'(err_count), 32'd0);
    check_value("reseed2_exp",    32'(exp_out),   32'd10);
    valid_in = 1'b0;

    // Saturation on the ERR_W=2 instance: 0,5,0,5,...
    for (int i = 0; i < 8; i++) begin
      q_sat     = (i % 2 == 1) ? 4'd5 : 4'd0;
      valid_sat = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) check_value("sat_seed_locked", 32'(locked_sat), 32'd1);
      if (i == 2) check_value("sat_err_two",     32'(err_sat),    32'd2);
      if (i == 3) check_value("sat_err_three",   32'(err_sat),    32'd3);
    end
    valid_sat = 1'b0;
    check_value("sat_err_hold", 32'(err_sat),    32'd3);
    check_value("sat_unlocked", 32'(locked_sat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
